// File: rtl/watch_edit_sequencer.sv
// Edit-mode sequencer for the watch datapath: field select, up/down edit pulses with
// hold-to-repeat, per-field blink mask and inactivity timeout.
module watch_edit_sequencer #(
    parameter int HOLD_CYC    = 50_000_000,
    parameter int REPEAT_CYC  = 10_000_000,
    parameter int TIMEOUT_CYC = 1_000_000_000,
    parameter int BLINK_CYC   = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_edit,
    input  logic       i_watch_select,
    input  logic       i_up,
    input  logic       i_down,
    input  logic       i_left,
    input  logic       i_right,
    output logic [1:0] o_edit_msec,
    output logic [1:0] o_edit_sec,
    output logic [1:0] o_edit_min,
    output logic [1:0] o_edit_hour,
    output logic [1:0] o_field,
    output logic       o_edit_active,
    output logic [3:0] o_blank,
    output logic       o_timeout
);

    localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam int RW = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYC - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);
    localparam logic [BW-1:0] BL_LAST   = BW'(BLINK_CYC - 1);

    localparam logic [1:0] CODE_NONE = 2'b00;
    localparam logic [1:0] CODE_INC  = 2'b01;
    localparam logic [1:0] CODE_DEC  = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_PRESS,
        S_REPEAT,
        S_LOCK
    } state_t;

    state_t        state, state_nxt;
    logic          up_q, down_q, left_q, right_q;
    logic          up_rise, down_rise, left_rise, right_rise, any_rise;
    logic          dir_q, dir_nxt;
    logic          block_q, block_nxt;
    logic          held;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic [RW-1:0] rep_cnt, rep_nxt;
    logic [TW-1:0] to_cnt, to_nxt, to_inc;
    logic [BW-1:0] blink_cnt, blink_nxt;
    logic          phase_q, phase_nxt;
    logic          blink_restart;
    logic [1:0]    field_nxt;
    logic [1:0]    code_nxt;
    logic          timeout_nxt;
    logic          active_nxt;

    assign up_rise    = i_up & ~up_q;
    assign down_rise  = i_down & ~down_q;
    assign left_rise  = i_left & ~left_q;
    assign right_rise = i_right & ~right_q;
    assign any_rise   = up_rise | down_rise | left_rise | right_rise;
    assign held       = dir_q ? i_down : i_up;
    assign to_inc     = (to_cnt == TO_LAST) ? to_cnt : to_cnt + TW'(1);

    // Next-state, edit pulse, timeout and counter control.
    always_comb begin
        state_nxt     = state;
        field_nxt     = o_field;
        code_nxt      = CODE_NONE;
        timeout_nxt   = 1'b0;
        dir_nxt       = dir_q;
        block_nxt     = block_q & (i_up | i_down);
        hold_nxt      = hold_cnt;
        rep_nxt       = rep_cnt;
        to_nxt        = to_cnt;
        blink_restart = 1'b0;

        case (state)
            S_IDLE: begin
                to_nxt        = '0;
                blink_restart = 1'b1;
                if (i_edit && !i_watch_select) begin
                    state_nxt = S_WAIT;
                    field_nxt = 2'd1;
                end
            end
            S_LOCK: begin
                to_nxt = '0;
                if (!i_edit)
                    state_nxt = S_IDLE;
            end
            default: begin
                to_nxt = (any_rise || i_up || i_down) ? '0 : to_inc;
                if (!i_edit || i_watch_select) begin
                    state_nxt = S_IDLE;
                end else if (to_nxt == TO_LAST) begin
                    state_nxt   = S_LOCK;
                    timeout_nxt = 1'b1;
                end else if (state == S_WAIT) begin
                    // A pending both-buttons block suppresses every new edge until both are low.
                    if (!block_q) begin
                        if (up_rise && !i_down) begin
                            code_nxt      = CODE_INC;
                            dir_nxt       = 1'b0;
                            hold_nxt      = '0;
                            state_nxt     = S_PRESS;
                            blink_restart = 1'b1;
                        end else if (down_rise && !i_up) begin
                            code_nxt      = CODE_DEC;
                            dir_nxt       = 1'b1;
                            hold_nxt      = '0;
                            state_nxt     = S_PRESS;
                            blink_restart = 1'b1;
                        end else if (!up_rise && !down_rise) begin
                            if (left_rise && !right_rise) begin
                                field_nxt     = o_field + 2'd1;
                                blink_restart = 1'b1;
                            end else if (right_rise && !left_rise) begin
                                field_nxt     = o_field - 2'd1;
                                blink_restart = 1'b1;
                            end
                        end
                    end
                end else begin
                    if (i_up && i_down) begin
                        state_nxt = S_WAIT;
                        block_nxt = 1'b1;
                    end else if (!held) begin
                        state_nxt = S_WAIT;
                    end else if (state == S_PRESS) begin
                        if (hold_cnt == HOLD_LAST) begin
                            code_nxt      = dir_q ? CODE_DEC : CODE_INC;
                            rep_nxt       = '0;
                            state_nxt     = S_REPEAT;
                            blink_restart = 1'b1;
                        end else begin
                            hold_nxt = hold_cnt + HW'(1);
                        end
                    end else begin
                        if (rep_cnt == REP_LAST) begin
                            code_nxt      = dir_q ? CODE_DEC : CODE_INC;
                            rep_nxt       = '0;
                            blink_restart = 1'b1;
                        end else begin
                            rep_nxt = rep_cnt + RW'(1);
                        end
                    end
                end
            end
        endcase

        active_nxt = (state_nxt == S_WAIT) || (state_nxt == S_PRESS) || (state_nxt == S_REPEAT);

        blink_nxt = blink_cnt;
        phase_nxt = phase_q;
        if (blink_restart || !active_nxt) begin
            blink_nxt = '0;
            phase_nxt = 1'b0;
        end else if (blink_cnt == BL_LAST) begin
            blink_nxt = '0;
            phase_nxt = ~phase_q;
        end else begin
            blink_nxt = blink_cnt + BW'(1);
        end
    end

    // State, counters, button history and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            up_q          <= 1'b0;
            down_q        <= 1'b0;
            left_q        <= 1'b0;
            right_q       <= 1'b0;
            dir_q         <= 1'b0;
            block_q       <= 1'b0;
            hold_cnt      <= '0;
            rep_cnt       <= '0;
            to_cnt        <= '0;
            blink_cnt     <= '0;
            phase_q       <= 1'b0;
            o_edit_msec   <= CODE_NONE;
            o_edit_sec    <= CODE_NONE;
            o_edit_min    <= CODE_NONE;
            o_edit_hour   <= CODE_NONE;
            o_field       <= 2'd1;
            o_edit_active <= 1'b0;
            o_blank       <= 4'b0000;
            o_timeout     <= 1'b0;
        end else begin
            state         <= state_nxt;
            up_q          <= i_up;
            down_q        <= i_down;
            left_q        <= i_left;
            right_q       <= i_right;
            dir_q         <= dir_nxt;
            block_q       <= block_nxt;
            hold_cnt      <= hold_nxt;
            rep_cnt       <= rep_nxt;
            to_cnt        <= to_nxt;
            blink_cnt     <= blink_nxt;
            phase_q       <= phase_nxt;
            o_edit_msec   <= (o_field == 2'd0) ? code_nxt : CODE_NONE;
            o_edit_sec    <= (o_field == 2'd1) ? code_nxt : CODE_NONE;
            o_edit_min    <= (o_field == 2'd2) ? code_nxt : CODE_NONE;
            o_edit_hour   <= (o_field == 2'd3) ? code_nxt : CODE_NONE;
            o_field       <= field_nxt;
            o_edit_active <= active_nxt;
            o_blank       <= phase_nxt ? (4'b0001 << field_nxt) : 4'b0000;
            o_timeout     <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_watch_edit_sequencer.sv
// Directed bench for watch_edit_sequencer with small timing parameters and
// hand-computed expected codes, field, blink and timeout values.
module tb_watch_edit_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_edit, i_watch_select;
    logic       i_up, i_down, i_left, i_right;
    logic [1:0] o_edit_msec, o_edit_sec, o_edit_min, o_edit_hour;
    logic [1:0] o_field;
    logic       o_edit_active;
    logic [3:0] o_blank;
    logic       o_timeout;

    int testsRun    = 0;
    int testsFailed = 0;

    localparam logic [3:0] BTN_NONE = 4'b0000;
    localparam logic [3:0] BTN_U    = 4'b1000;
    localparam logic [3:0] BTN_D    = 4'b0100;
    localparam logic [3:0] BTN_L    = 4'b0010;
    localparam logic [3:0] BTN_R    = 4'b0001;

    watch_edit_sequencer #(
        .HOLD_CYC   (8),
        .REPEAT_CYC (3),
        .TIMEOUT_CYC(40),
        .BLINK_CYC  (5)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_edit        (i_edit),
        .i_watch_select(i_watch_select),
        .i_up          (i_up),
        .i_down        (i_down),
        .i_left        (i_left),
        .i_right       (i_right),
        .o_edit_msec   (o_edit_msec),
        .o_edit_sec    (o_edit_sec),
        .o_edit_min    (o_edit_min),
        .o_edit_hour   (o_edit_hour),
        .o_field       (o_field),
        .o_edit_active (o_edit_active),
        .o_blank       (o_blank),
        .o_timeout     (o_timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] codes();
        return {o_edit_hour, o_edit_min, o_edit_sec, o_edit_msec};
    endfunction

    // Drive the buttons for one clock and settle just after the edge that samples them.
    task automatic applyStimulus(input logic [3:0] btn);
        {i_up, i_down, i_left, i_right} = btn;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tapField(input logic [3:0] btn, input logic [1:0] expField, input string tag);
        applyStimulus(btn);
        checkOutput(tag, {6'd0, o_field}, {6'd0, expField});
        applyStimulus(BTN_NONE);
    endtask

    initial begin
        logic [7:0] expCodes;
        logic [3:0] expBlank;

        reset = 1'b1;
        i_edit = 1'b0;
        i_watch_select = 1'b0;
        {i_up, i_down, i_left, i_right} = BTN_NONE;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_codes", codes(), 8'h00);
        checkOutput("reset_field", {6'd0, o_field}, 8'd1);
        checkOutput("reset_active", {7'd0, o_edit_active}, 8'd0);
        checkOutput("reset_blank", {4'd0, o_blank}, 8'd0);
        checkOutput("reset_timeout", {7'd0, o_timeout}, 8'd0);

        // 1: entry and field navigation
        reset = 1'b0;
        i_edit = 1'b1;
        applyStimulus(BTN_NONE);
        checkOutput("entry_active", {7'd0, o_edit_active}, 8'd1);
        checkOutput("entry_field", {6'd0, o_field}, 8'd1);
        tapField(BTN_L, 2'd2, "left_1");
        tapField(BTN_L, 2'd3, "left_2");
        tapField(BTN_L, 2'd0, "left_wrap");
        tapField(BTN_R, 2'd3, "right_wrap");
        tapField(BTN_L | BTN_R, 2'd3, "left_right_together");
        tapField(BTN_L, 2'd0, "left_3");
        tapField(BTN_L, 2'd1, "left_4");

        // 2: hold-to-repeat on seconds
        for (int i = 0; i < 20; i++) begin
            applyStimulus(BTN_U);
            expCodes = (i == 0 || i == 8 || i == 11 || i == 14 || i == 17) ? 8'h04 : 8'h00;
            checkOutput($sformatf("hold_up_%0d", i), codes(), expCodes);
        end
        applyStimulus(BTN_NONE);
        checkOutput("hold_release", codes(), 8'h00);

        // 3: single down tap on minutes, then both buttons together
        tapField(BTN_L, 2'd2, "to_min");
        applyStimulus(BTN_D);
        checkOutput("down_tap", codes(), 8'h30);
        applyStimulus(BTN_NONE);
        checkOutput("down_tap_end", codes(), 8'h00);
        applyStimulus(BTN_U | BTN_D);
        checkOutput("both_edge", codes(), 8'h00);
        applyStimulus(BTN_U | BTN_D);
        checkOutput("both_hold", codes(), 8'h00);
        applyStimulus(BTN_NONE);
        checkOutput("both_still_active", {7'd0, o_edit_active}, 8'd1);
        applyStimulus(BTN_U);
        checkOutput("up_after_both", codes(), 8'h10);
        applyStimulus(BTN_U | BTN_L);
        checkOutput("up_held_left_ignored", {6'd0, o_field}, 8'd2);
        applyStimulus(BTN_NONE);
        applyStimulus(BTN_U | BTN_R);
        checkOutput("up_with_right_code", codes(), 8'h10);
        checkOutput("up_with_right_field", {6'd0, o_field}, 8'd2);
        applyStimulus(BTN_NONE);

        // 4: blink and timeout
        i_edit = 1'b0;
        applyStimulus(BTN_NONE);
        checkOutput("exit_active", {7'd0, o_edit_active}, 8'd0);
        checkOutput("exit_field_holds", {6'd0, o_field}, 8'd2);
        i_edit = 1'b1;
        applyStimulus(BTN_NONE);
        checkOutput("reentry_field", {6'd0, o_field}, 8'd1);
        checkOutput("reentry_blank", {4'd0, o_blank}, 8'd0);
        for (int k = 1; k < 40; k++) begin
            applyStimulus(BTN_NONE);
            if (k < 39) begin
                expBlank = ((k / 5) % 2 == 1) ? 4'b0010 : 4'b0000;
                checkOutput($sformatf("blink_%0d", k), {4'd0, o_blank}, {4'd0, expBlank});
                checkOutput($sformatf("no_timeout_%0d", k), {7'd0, o_timeout}, 8'd0);
            end else begin
                checkOutput("timeout_pulse", {7'd0, o_timeout}, 8'd1);
                checkOutput("timeout_active", {7'd0, o_edit_active}, 8'd0);
                checkOutput("timeout_blank", {4'd0, o_blank}, 8'd0);
            end
        end
        applyStimulus(BTN_NONE);
        checkOutput("timeout_one_cycle", {7'd0, o_timeout}, 8'd0);
        repeat (3) applyStimulus(BTN_NONE);
        checkOutput("lock_holds", {7'd0, o_edit_active}, 8'd0);
        applyStimulus(BTN_U);
        checkOutput("lock_no_code", codes(), 8'h00);
        applyStimulus(BTN_NONE);
        i_edit = 1'b0;
        applyStimulus(BTN_NONE);
        checkOutput("lock_exit", {7'd0, o_edit_active}, 8'd0);
        i_edit = 1'b1;
        applyStimulus(BTN_NONE);
        checkOutput("lock_reentry", {7'd0, o_edit_active}, 8'd1);

        // 5: leaving edit mode in REPEAT via i_edit, then via i_watch_select
        for (int i = 0; i < 11; i++) applyStimulus(BTN_U);
        i_edit = 1'b0;
        applyStimulus(BTN_U);
        checkOutput("edit_drop_codes", codes(), 8'h00);
        checkOutput("edit_drop_active", {7'd0, o_edit_active}, 8'd0);
        applyStimulus(BTN_U);
        checkOutput("edit_drop_codes_2", codes(), 8'h00);
        applyStimulus(BTN_NONE);
        i_edit = 1'b1;
        applyStimulus(BTN_NONE);
        for (int i = 0; i < 11; i++) begin
            applyStimulus(BTN_U);
            if (i == 8) checkOutput("sel_repeat_pulse", codes(), 8'h04);
        end
        i_watch_select = 1'b1;
        applyStimulus(BTN_U);
        checkOutput("sel_codes", codes(), 8'h00);
        checkOutput("sel_active", {7'd0, o_edit_active}, 8'd0);
        applyStimulus(BTN_NONE);
        checkOutput("sel_blank", {4'd0, o_blank}, 8'd0);
        i_watch_select = 1'b0;
        applyStimulus(BTN_NONE);
        checkOutput("sel_reentry", {7'd0, o_edit_active}, 8'd1);

        // 6: asynchronous reset while repeating
        tapField(BTN_L, 2'd2, "pre_reset_field");
        for (int i = 0; i < 10; i++) applyStimulus(BTN_U);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_codes", codes(), 8'h00);
        checkOutput("async_field", {6'd0, o_field}, 8'd1);
        checkOutput("async_active", {7'd0, o_edit_active}, 8'd0);
        checkOutput("async_blank", {4'd0, o_blank}, 8'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(BTN_U);
            checkOutput($sformatf("post_reset_%0d", i), codes(), 8'h00);
        end
        checkOutput("post_reset_active", {7'd0, o_edit_active}, 8'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
